spi_read_fifo: RTL and testbench
================================

Name: spi_read_fifo

Overview:
- Downstream stage of the SPI read engine: captures each byte announced by the engine's byte-complete strobe into a byte FIFO.
- Presents the bytes to the host/AXI side on a first-word-fall-through valid/ready stream.
- Tracks per-transaction byte counts, signals transaction completion, and flags sticky overflow.

Parameters:
- REG_WIDTH, 8, width of one data byte/register word.
- DEPTH, 16, FIFO entries; must be a power of two, minimum 2.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rstn  input  1  asynchronous active-low reset.
- in_data  input  REG_WIDTH  byte from read engine (data_read_from_reg).
- in_byte_valid  input  1  byte-complete strobe (read_one_byte_complete).
- in_read_complete  input  1  transaction-complete strobe (read_complete).
- flush  input  1  synchronous FIFO clear.
- clr_overflow  input  1  clears sticky overflow.
- m_data  output  REG_WIDTH  head-of-FIFO byte.
- m_valid  output  1  FIFO not empty.
- m_ready  input  1  consumer accepts m_data when m_valid=1.
- fifo_count  output  $clog2(DEPTH)+1  occupied entries.
- full  output  1  fifo_count==DEPTH.
- overflow  output  1  sticky: a byte was dropped.
- txn_done  output  1  one-cycle pulse at end of transaction.
- txn_byte_count  output  8  bytes accepted in last completed transaction.

Behaviour:
- Reset (async, rstn=0): pointers=0, fifo_count=0, m_valid=0, full=0, overflow=0, txn_done=0, txn_byte_count=0, running byte counter=0, edge-detect registers=0. m_data is don't-care while m_valid=0.
- Edge detect: push when in_byte_valid=1 and its previous-cycle value=0. A strobe held high for N cycles yields exactly one push. Completion event is defined the same way on in_read_complete.
- Push samples in_data on the same clock edge. The byte is visible on m_data/m_valid the cycle after that edge (latency 1).
- Pop occurs when m_valid && m_ready at a posedge. The next entry appears on m_data in the same cycle the pointer advances; no extra bubble.
- Storage: circular buffer, write/read pointers of $clog2(DEPTH) bits wrapping naturally. fifo_count is tracked explicitly.
- Push while full with no pop that cycle: byte dropped, pointers unchanged, overflow<=1. Running count is not incremented.
- Simultaneous push and pop while full: both performed, byte accepted, count unchanged, no overflow.
- Simultaneous push and pop while empty: pop is ignored (m_valid=0), push accepted.
- flush=1: pointers and fifo_count go to 0 next cycle; push/pop in that cycle are discarded. Running byte counter is also cleared. overflow and txn_byte_count are unaffected.
- clr_overflow=1 clears overflow. If a dropping push occurs the same cycle, overflow stays 1 (set wins).
- Transaction tracking: the running counter (8 bits, saturates at 255) increments on each accepted push.
- On a completion event: txn_byte_count <= running count including any push accepted that same cycle; txn_done pulses 1 for one cycle; running counter <= 0.
- The read engine raises its final byte strobe and read_complete in the same cycle; that byte must be counted in the finishing transaction.
- Completion event with zero bytes: txn_done pulses, txn_byte_count=0.
- Reset mid-transaction: all state lost, no txn_done generated.

Optional Feature:
- Macro SPI_READ_FIFO_TLAST_EN.
- Defined: each entry stores an extra last bit, set when the pushed byte coincides with a completion event. A new output port m_last (1 bit) accompanies m_data, valid only with m_valid; reset 0.
- Undefined: no m_last port, entries are REG_WIDTH bits, all other behaviour identical.

Test Plan:
- Reset, then 3 single-cycle strobes with in_data 0xA5, 0x3C, 0x81, m_ready=0 -> fifo_count=3, m_data=0xA5 one cycle after the first strobe. Then m_ready=1 -> 0xA5, 0x3C, 0x81 on consecutive cycles, m_valid=0 after.
- in_byte_valid held high 4 cycles with in_data=0x55 -> exactly one entry, fifo_count=1.
- DEPTH=16: push 17 bytes 0x00..0x10, m_ready=0 -> full=1, overflow=1, fifo contents 0x00..0x0F. clr_overflow pulse -> overflow=0.
- Full FIFO, push 0x77 together with m_ready=1 -> count stays 16, no overflow, 0x77 is the last byte drained.
- 5 pushes, final push coincident with in_read_complete rise -> txn_done single pulse, txn_byte_count=5. With SPI_READ_FIFO_TLAST_EN, m_last=1 only on the 5th byte.
- 4 bytes queued, flush=1 with a simultaneous push -> next cycle fifo_count=0, m_valid=0, and a subsequent completion gives txn_byte_count=0.

Source files
------------

// File: rtl/spi_read_fifo.sv
// Byte FIFO behind the SPI read engine. Presents bytes on a first-word-fall-through
// stream and tracks per-transaction byte counts. Optional TLAST: SPI_READ_FIFO_TLAST_EN.
module spi_read_fifo #(
  parameter int REG_WIDTH = 8,
  parameter int DEPTH     = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [REG_WIDTH-1:0]       in_data,
  input  logic                       in_byte_valid,
  input  logic                       in_read_complete,
  input  logic                       flush,
  input  logic                       clr_overflow,
  output logic [REG_WIDTH-1:0]       m_data,
  output logic                       m_valid,
`ifdef SPI_READ_FIFO_TLAST_EN
  output logic                       m_last,
`endif
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       full,
  output logic                       overflow,
  output logic                       txn_done,
  output logic [7:0]                 txn_byte_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
`ifdef SPI_READ_FIFO_TLAST_EN
  localparam int EW = REG_WIDTH + 1;
`else
  localparam int EW = REG_WIDTH;
`endif

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          byte_q;
  logic          done_q;
  logic [7:0]    run_cnt;
  logic [7:0]    run_next;
  logic          push_ev;
  logic          done_ev;
  logic          pop_ok;
  logic          accept;
  logic          drop;

  assign push_ev = in_byte_valid & ~byte_q;
  assign done_ev = in_read_complete & ~done_q;

  assign m_valid    = (count != '0);
  assign full       = (count == DEPTH_C);
  assign fifo_count = count;

  // A full FIFO can still take a byte when the consumer frees a slot the same cycle.
  assign pop_ok = m_valid & m_ready & ~flush;
  assign accept = push_ev & ~flush & (~full | pop_ok);
  assign drop   = push_ev & ~flush & full & ~pop_ok;

  assign run_next = accept ? ((run_cnt == 8'hFF) ? 8'hFF : run_cnt + 8'd1) : run_cnt;

`ifdef SPI_READ_FIFO_TLAST_EN
  assign wr_entry = {done_ev, in_data};
  assign m_last   = m_valid & rd_entry[REG_WIDTH];
`else
  assign wr_entry = in_data;
`endif

  assign rd_entry = mem[rd_ptr];
  assign m_data   = rd_entry[REG_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      byte_q <= in_byte_valid;
      done_q <= in_read_complete;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({accept, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Dropping push beats a same-cycle clear so no lost byte goes unreported.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_cnt        <= 8'd0;
      txn_done       <= 1'b0;
      txn_byte_count <= 8'd0;
    end else begin
      txn_done <= done_ev;
      if (done_ev) begin
        txn_byte_count <= run_next;
        run_cnt        <= 8'd0;
      end else if (flush) begin
        run_cnt <= 8'd0;
      end else begin
        run_cnt <= run_next;
      end
    end
  end

endmodule

// File: tb/tb_spi_read_fifo.sv
// Self-checking bench for spi_read_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_spi_read_fifo;
  localparam int RW = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic [RW-1:0] din;
  logic          bv, rc, fl, clr, rdy;
  logic [RW-1:0] m_data;
  logic          m_valid;
  logic          m_last_w;
  logic [4:0]    fifo_count;
  logic          full, overflow, txn_done;
  logic [7:0]    txn_byte_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  byte unsigned q[$];
  bit           lq[$];
  bit           prev_bv, prev_rc, m_ovf, m_done;
  int           m_run, m_txn;

  always #5 clk = ~clk;

  spi_read_fifo #(.REG_WIDTH(RW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .in_data(din), .in_byte_valid(bv),
    .in_read_complete(rc), .flush(fl), .clr_overflow(clr),
    .m_data(m_data), .m_valid(m_valid),
`ifdef SPI_READ_FIFO_TLAST_EN
    .m_last(m_last_w),
`endif
    .m_ready(rdy), .fifo_count(fifo_count), .full(full), .overflow(overflow),
    .txn_done(txn_done), .txn_byte_count(txn_byte_count)
  );

`ifndef SPI_READ_FIFO_TLAST_EN
  assign m_last_w = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit pe, ce, popped, acc;
    pe = bv && !prev_bv;
    ce = rc && !prev_rc;
    acc = 1'b0;
    if (fl) begin
      q.delete();
      lq.delete();
      m_run = 0;
      if (clr) m_ovf = 1'b0;
    end else begin
      popped = rdy && (q.size() > 0);
      acc = pe && ((q.size() < DEPTH) || popped);
      if (popped) begin
        void'(q.pop_front());
        void'(lq.pop_front());
      end
      if (acc) begin
        q.push_back(din);
        lq.push_back(ce);
      end
      if (pe && !acc) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (acc && m_run < 255) m_run++;
    end
    m_done = ce;
    if (ce) begin
      m_txn = m_run;
      m_run = 0;
    end
    prev_bv = bv;
    prev_rc = rc;
  endtask

  task automatic check_all();
    chk("m_valid", m_valid, q.size() != 0);
    chk("fifo_count", fifo_count, q.size());
    chk("full", full, q.size() == DEPTH);
    chk("overflow", overflow, m_ovf);
    chk("txn_done", txn_done, m_done);
    chk("txn_byte_count", txn_byte_count, m_txn);
    if (q.size() != 0) chk("m_data", m_data, q[0]);
`ifdef SPI_READ_FIFO_TLAST_EN
    chk("m_last", m_last_w, (q.size() != 0) ? lq[0] : 1'b0);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic strobe(input logic [7:0] d);
    din = d; bv = 1'b1; tick();
    bv = 1'b0; tick();
  endtask

  initial begin
    rstn = 1'b0; din = '0; bv = 0; rc = 0; fl = 0; clr = 0; rdy = 0;
    prev_bv = 0; prev_rc = 0; m_ovf = 0; m_done = 0; m_run = 0; m_txn = 0;
    repeat (3) @(negedge clk);
    check_all();
    chk("reset_count", fifo_count, 0);
    rstn = 1'b1;

    // three strobes, then drain in consecutive cycles
    din = 8'hA5; bv = 1; tick();
    chk("first_byte", m_data, 8'hA5);
    bv = 0; tick();
    strobe(8'h3C);
    strobe(8'h81);
    chk("count3", fifo_count, 3);
    rdy = 1; tick();
    chk("second_byte", m_data, 8'h3C);
    tick();
    chk("third_byte", m_data, 8'h81);
    tick();
    chk("drained", m_valid, 0);

    // held strobe is one push
    rdy = 0; din = 8'h55; bv = 1;
    repeat (4) tick();
    chk("held_one", fifo_count, 1);
    bv = 0; rdy = 1; tick();
    rdy = 0;

    // overfill
    for (int i = 0; i < 17; i++) strobe(8'(i));
    chk("full_set", full, 1);
    chk("ovf_set", overflow, 1);
    chk("head_after_fill", m_data, 8'h00);
    clr = 1; tick(); clr = 0;
    chk("ovf_clr", overflow, 0);

    // push with pop while full
    din = 8'h77; bv = 1; rdy = 1; tick();
    chk("full_pushpop_count", fifo_count, 16);
    chk("full_pushpop_ovf", overflow, 0);
    bv = 0; rdy = 0; tick();
    rdy = 1;
    repeat (15) tick();
    chk("last_drained", m_data, 8'h77);
    tick();
    chk("empty_again", m_valid, 0);
    rdy = 0;

    // close stale run, then a 5-byte transaction
    rc = 1; tick(); rc = 0; tick();
    for (int i = 0; i < 4; i++) strobe(8'hB0 + 8'(i));
    din = 8'hB4; bv = 1; rc = 1; tick();
    chk("txn_pulse", txn_done, 1);
    chk("txn_count5", txn_byte_count, 5);
    bv = 0; tick();
    chk("txn_pulse_end", txn_done, 0);
    rc = 0;
    rdy = 1; repeat (5) tick(); rdy = 0;

    // flush with a coincident push
    for (int i = 0; i < 4; i++) strobe(8'hC0 + 8'(i));
    din = 8'hCF; bv = 1; fl = 1; tick();
    fl = 0; bv = 0;
    chk("flush_count", fifo_count, 0);
    chk("flush_valid", m_valid, 0);
    rc = 1; tick(); rc = 0;
    chk("flush_txn", txn_byte_count, 0);
    tick();

    // zero-byte completion and counter saturation
    rc = 1; tick(); rc = 0; tick();
    chk("zero_txn", txn_byte_count, 0);
    rdy = 1;
    for (int i = 0; i < 260; i++) strobe(8'(i));
    rc = 1; tick(); rc = 0; tick();
    chk("sat_txn", txn_byte_count, 255);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      din = 8'($urandom);
      bv  = ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 49) == 0);
      clr = ($urandom_range(0, 19) == 0);
      rc  = fl ? 1'b0 : ($urandom_range(0, 15) == 0);
      tick();
    end
    bv = 0; rc = 0; fl = 0; clr = 0; rdy = 0;

    // reset mid-transaction
    strobe(8'h11);
    rstn = 0;
    q.delete(); lq.delete();
    prev_bv = 0; prev_rc = 0; m_ovf = 0; m_done = 0; m_run = 0; m_txn = 0;
    @(negedge clk);
    check_all();
    rstn = 1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
